// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes stage. A 128-bit state is latched on the input
// handshake and substituted LANES bytes per cycle, working from byte 0 (MSB)
// toward byte 15. The finished state is then presented on a registered output
// until the consumer accepts it.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. in_ready is a pure function of state. out_valid
// never looks at out_ready. clear overrides everything, so an in_valid seen
// together with clear is not taken even though in_ready reads 1.
module inv_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    localparam int NCHUNK = 16 / LANES;
    localparam logic [3:0] LAST = 4'(NCHUNK - 1);

    // Only divisors of 16 up to 16 give a whole number of chunks per block.
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // State is kept as a named enum so checkers can bind to it directly.
    state_t       state;
    state_t       state_next;
    logic [3:0]   cnt;
    logic [127:0] work;
    logic [127:0] work_next;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    // Inverse S-box: undo the affine map (b_i = s_{i+2}^s_{i+5}^s_{i+7}^0x05), then invert.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[1] ^ s[4] ^ s[6], s[0] ^ s[3] ^ s[5], s[7] ^ s[2] ^ s[4], s[6] ^ s[1] ^ s[3],
             s[5] ^ s[0] ^ s[2], s[4] ^ s[7] ^ s[1], s[3] ^ s[6] ^ s[0], s[2] ^ s[5] ^ s[7]}
            ^ 8'h05;
        return gf_inv(b);
    endfunction

    // Substitute the current chunk of LANES bytes in place; one S-box per lane.
    always_comb begin
        logic [3:0] pos;
        logic [6:0] lsb;
        work_next = work;
        pos       = 4'd0;
        lsb       = 7'd0;
        for (int l = 0; l < LANES; l++) begin
            pos = 4'(32'(cnt) * LANES + l);
            lsb = 7'(8 * (15 - 32'(pos)));
            work_next[lsb +: 8] = inv_sbox(work[lsb +: 8]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; clear wins over every transition.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_next = BUSY;
                BUSY:    if (cnt == LAST) state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: latch on accept, substitute while busy, register the final state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 4'd0;
            work     <= 128'd0;
            data_out <= 128'd0;
        end else if (clear) begin
            cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= data_in;
                        cnt  <= 4'd0;
                    end
                end
                BUSY: begin
                    work <= work_next;
                    cnt  <= cnt + 4'd1;
                    if (cnt == LAST) data_out <= work_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter. Five instances (LANES = 1, 2, 4, 8, 16) share
// the input side; the LANES=4 instance (index 2) is the main target. Expected
// data comes from an inverse S-box table built by inverting a forward S-box
// computed from the GF(2^8) field definition.
module tb_inv_sub_bytes_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] data_in = '0;
    logic [4:0]   ir;
    logic [4:0]   ov;
    logic [127:0] dout [5];

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [127:0] exp_q [$];

    inv_sub_bytes_iter #(.LANES(1)) u_l1 (.clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(ir[0]), .data_in(data_in), .out_valid(ov[0]), .out_ready(out_ready), .data_out(dout[0]));
    inv_sub_bytes_iter #(.LANES(2)) u_l2 (.clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(ir[1]), .data_in(data_in), .out_valid(ov[1]), .out_ready(out_ready), .data_out(dout[1]));
    inv_sub_bytes_iter #(.LANES(4)) u_l4 (.clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(ir[2]), .data_in(data_in), .out_valid(ov[2]), .out_ready(out_ready), .data_out(dout[2]));
    inv_sub_bytes_iter #(.LANES(8)) u_l8 (.clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(ir[3]), .data_in(data_in), .out_valid(ov[3]), .out_ready(out_ready), .data_out(dout[3]));
    inv_sub_bytes_iter #(.LANES(16)) u_l16 (.clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(ir[4]), .data_in(data_in), .out_valid(ov[4]), .out_ready(out_ready), .data_out(dout[4]));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        logic [15:0] t;
        t = {b, b} << k;
        return t[15:8];
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int y = 1; y < 256; y++)
                if (fmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox[x] = b;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    endtask

    function automatic logic [127:0] ref_block(input logic [127:0] d);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[8*(15-j) +: 8] = isbox[d[8*(15-j) +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] splat(input logic [7:0] b);
        return {16{b}};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // Present a block to the main instance and take it on one edge.
    task automatic send(input logic [127:0] d);
        int n = 0;
        while (!ir[2] && n < 40) begin step(); n++; end
        if (!ir[2]) check("send_timeout", 0, 1);
        in_valid = 1'b1;
        data_in  = d;
        step();
        in_valid = 1'b0;
    endtask

    // Wait for main out_valid; edges counted from the accept edge, inclusive.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!ov[2] && lat < 40) begin step(); lat++; end
        if (!ov[2]) check("out_timeout", 0, 1);
    endtask

    task automatic run_check(input string tag, input logic [127:0] d, output logic [127:0] got);
        int lat;
        out_ready = 1'b1;
        send(d);
        wait_out(lat);
        check({tag, "_lat"}, 128'(lat), 128'd5);
        got = dout[2];
        check(tag, got, ref_block(d));
        step();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] got;
        logic [127:0] hold;
        logic [127:0] blk [4];
        int lat [5];
        int lat_exp [5];
        int got_n;
        int last_t;
        int k;
        logic saw;

        lat_exp = '{17, 9, 5, 3, 2};
        build_tables();

        // Reset values
        rst_n = 1'b0;
        #3;
        check("rst_in_ready", 128'(ir[2]), 128'd1);
        check("rst_out_valid", 128'(ov[2]), 128'd0);
        check("rst_data_out", dout[2], 128'd0);
        do_reset();

        // Single-value vectors against fixed FIPS-197 entries
        run_check("splat63", splat(8'h63), got);
        check("splat63_const", got, splat(8'h00));
        run_check("splat00", splat(8'h00), got);
        check("splat00_const", got, splat(8'h52));
        run_check("splat16", splat(8'h16), got);
        check("splat16_const", got, splat(8'hff));

        // FIPS-197 C.1 vector on every LANES value, with latency
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
        step();
        in_valid = 1'b0;
        lat = '{0, 0, 0, 0, 0};
        for (int e = 2; e <= 24; e++) begin
            step();
            for (int i = 0; i < 5; i++)
                if (ov[i] && lat[i] == 0) begin
                    lat[i] = e;
                    check($sformatf("fips_data_%0d", i), dout[i], 128'hbd6e7c3df2b5779e0b61216e8b10b689);
                end
        end
        for (int i = 0; i < 5; i++) check($sformatf("fips_lat_%0d", i), 128'(lat[i]), 128'(lat_exp[i]));

        // Backpressure: hold result, refuse a second block
        do_reset();
        blk[0] = {$urandom, $urandom, $urandom, $urandom};
        blk[1] = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b0;
        send(blk[0]);
        wait_out(k);
        hold = dout[2];
        check("bp_first", hold, ref_block(blk[0]));
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            data_in  = blk[1];
            step();
            check("bp_valid", 128'(ov[2]), 128'd1);
            check("bp_stable", dout[2], hold);
            check("bp_in_ready", 128'(ir[2]), 128'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_valid", 128'(ov[2]), 128'd0);
        check("bp_release_ready", 128'(ir[2]), 128'd1);
        step();
        in_valid = 1'b0;
        check("bp_second_taken", 128'(ir[2]), 128'd0);
        wait_out(k);
        check("bp_second_lat", 128'(k), 128'd5);
        check("bp_second_data", dout[2], ref_block(blk[1]));
        step();

        // Back-to-back with scoreboard and spacing
        do_reset();
        for (int i = 0; i < 4; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = blk[0];
        k = 0; got_n = 0; last_t = -1;
        for (int t = 0; t < 60 && got_n < 4; t++) begin
            if (in_valid && ir[2]) begin
                exp_q.push_back(ref_block(data_in));
                k++;
            end
            step();
            if (k < 4) data_in = blk[k];
            else in_valid = 1'b0;
            if (ov[2]) begin
                if (exp_q.size() == 0) check("b2b_unexpected", 0, 1);
                else check($sformatf("b2b_data_%0d", got_n), dout[2], exp_q.pop_front());
                if (last_t >= 0) check($sformatf("b2b_gap_%0d", got_n), 128'(t - last_t), 128'd6);
                last_t = t;
                got_n++;
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 128'(got_n), 128'd4);
        step();

        // clear together with in_valid in IDLE: not accepted
        clear = 1'b1; in_valid = 1'b1; data_in = blk[0];
        step();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_idle_ready", 128'(ir[2]), 128'd1);

        // clear during BUSY at counter 2
        out_ready = 1'b1;
        send(blk[1]);
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_busy_ready", 128'(ir[2]), 128'd1);
        saw = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (ov[2]) saw = 1'b1;
            step();
        end
        check("clr_no_valid", 128'(saw), 128'd0);
        run_check("clr_next", blk[2], got);

        // Asynchronous reset in DONE
        out_ready = 1'b0;
        send(blk[3]);
        wait_out(k);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 128'(ov[2]), 128'd0);
        check("arst_data", dout[2], 128'd0);
        check("arst_ready", 128'(ir[2]), 128'd1);
        step();
        rst_n = 1'b1;

        // Exhaustive sweep of all byte values, plus forward round trip
        for (int b = 0; b < 16; b++) begin
            logic [127:0] d;
            for (int j = 0; j < 16; j++) d[8*(15-j) +: 8] = 8'(16 * b + j);
            run_check($sformatf("sweep_%0d", b), d, got);
            for (int j = 0; j < 16; j++)
                check($sformatf("fwd_%0d", 16 * b + j), 128'(sbox[got[8*(15-j) +: 8]]), 128'(d[8*(15-j) +: 8]));
        end

        // Random blocks
        for (int r = 0; r < 6; r++) begin
            run_check($sformatf("rand_%0d", r), {$urandom, $urandom, $urandom, $urandom}, got);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
